// File: rtl/rom_bus_pkg.sv
// Shared definitions for the ROM-side view of the 4-bit multiplexed
// instruction bus: frame-state encoding, phase indices into the one-hot
// phase vector, opcode constants and the two-word instruction classifier.
package rom_bus_pkg;

    // Eight bus cycles per instruction frame, plus IDLE until the first sync.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_M1,
        ST_M2,
        ST_X1,
        ST_X2,
        ST_X3
    } frame_state_e;

    // Bit positions in the one-hot phase vector.
    localparam int PH_A1 = 0;
    localparam int PH_A2 = 1;
    localparam int PH_A3 = 2;
    localparam int PH_M1 = 3;
    localparam int PH_M2 = 4;
    localparam int PH_X1 = 5;
    localparam int PH_X2 = 6;
    localparam int PH_X3 = 7;

    // Upper opcode nibbles (OPR).
    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_FIM_SRC = 4'h2;
    localparam logic [3:0] OPR_FIN_JIN = 4'h3;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;

    // Full I/O opcodes.
    localparam logic [7:0] OPC_WRR = 8'hE2;
    localparam logic [7:0] OPC_RDR = 8'hEA;

    // True when the frame after this opcode carries a second word or data
    // byte instead of an instruction. FIN is included because its next
    // frame is a data fetch rather than an opcode fetch.
    function automatic logic is_two_word(input logic [7:0] op);
        case (op[7:4])
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: return 1'b1;
            OPR_FIM_SRC, OPR_FIN_JIN:           return ~op[0];
            default:                            return 1'b0;
        endcase
    endfunction

    // SRC shares its OPR with FIM; the low bit tells them apart.
    function automatic logic is_src(input logic [7:0] op);
        return (op[7:4] == OPR_FIM_SRC) && op[0];
    endfunction

endpackage

// File: rtl/rom_frame_counter.sv
// Tracks the 8-cycle instruction frame from the CPU's sync pulse.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   halt          - freezes the frame position
//   sync          - high during X3; the following cycle is A1
//   phase[7:0]    - one-hot current bus cycle (all zero while IDLE)
//   frame_valid   - high while inside a frame (not IDLE)
module rom_frame_counter
    import rom_bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    input  logic       sync,
    output logic [7:0] phase,
    output logic       frame_valid
);

    frame_state_e state;
    frame_state_e state_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (!halt) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase       = '0;
        frame_valid = 1'b1;
        case (state)
            ST_IDLE: begin
                state_nxt   = ST_IDLE;
                frame_valid = 1'b0;
            end
            ST_A1: begin state_nxt = ST_A2; phase[PH_A1] = 1'b1; end
            ST_A2: begin state_nxt = ST_A3; phase[PH_A2] = 1'b1; end
            ST_A3: begin state_nxt = ST_M1; phase[PH_A3] = 1'b1; end
            ST_M1: begin state_nxt = ST_M2; phase[PH_M1] = 1'b1; end
            ST_M2: begin state_nxt = ST_X1; phase[PH_M2] = 1'b1; end
            ST_X1: begin state_nxt = ST_X2; phase[PH_X1] = 1'b1; end
            ST_X2: begin state_nxt = ST_X3; phase[PH_X2] = 1'b1; end
            ST_X3: begin state_nxt = ST_A1; phase[PH_X3] = 1'b1; end
            default: begin
                state_nxt   = ST_IDLE;
                frame_valid = 1'b0;
            end
        endcase
        // An early sync abandons the partial frame; it never reaches X3,
        // so nothing downstream classifies its opcode.
        if (sync) begin
            state_nxt = ST_A1;
        end
    end

endmodule

// File: rtl/rom_responder.sv
// Bus-side ROM page: answers opcode fetches on the 4-bit multiplexed bus
// and, optionally, provides the page's 4-bit I/O port.
// Optional feature macro: ROM_RESPONDER_IO_EN (SRC select, WRR, RDR).
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   halt                - freezes all state together with the CPU
//   sync, rom_cmd       - CPU frame marker and ROM command strobe
//   data_i              - nibble driven on the bus by the CPU
//   data_o, data_en     - nibble driven by this chip and its enable
//   prog_we/addr/data   - program-store write port (active during halt)
//   io_i, io_o          - external input port and output port latch
module rom_responder
    import rom_bus_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0,
    parameter int         DEPTH   = 256
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       halt,
    input  logic       sync,
    input  logic       rom_cmd,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       data_en,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [3:0] io_i,
    output logic [3:0] io_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] phase;
    logic       frame_valid;
    logic [7:0] mem [DEPTH];
    logic [3:0] addr_lo;
    logic [3:0] addr_mid;
    logic [7:0] addr_byte;
    logic [7:0] rd_byte;
    logic [7:0] opc_byte;
    logic [3:0] bus_nib;
    logic       hit;
    logic       second;
    logic       rdr_drive;

    rom_frame_counter u_frame (
        .clock       (clock),
        .reset       (reset),
        .halt        (halt),
        .sync        (sync),
        .phase       (phase),
        .frame_valid (frame_valid)
    );

    // Program store: written independently of halt, read asynchronously so
    // a same-cycle write is seen only after the edge.
    always_ff @(posedge clock) begin
        if (prog_we) begin
            mem[prog_addr[AW-1:0]] <= prog_data;
        end
    end

    assign addr_byte = {addr_mid, addr_lo};
    assign rd_byte   = mem[addr_byte[AW-1:0]];

    // The opcode byte is whatever is on the bus in M1/M2: our own drive
    // when we answered the fetch, otherwise another chip's via data_i.
    assign bus_nib = data_en ? data_o : data_i;

    // Address / opcode capture
    always_ff @(posedge clock) begin
        if (!halt) begin
            if (phase[PH_A1]) addr_lo         <= data_i;
            if (phase[PH_A2]) addr_mid        <= data_i;
            if (phase[PH_M1]) opc_byte[7:4]   <= bus_nib;
            if (phase[PH_M2]) opc_byte[3:0]   <= bus_nib;
        end
    end

    // Fetch match and two-word tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            hit    <= 1'b0;
            second <= 1'b0;
        end else if (!halt) begin
            if (phase[PH_A3]) hit <= rom_cmd && (data_i == CHIP_ID);
            if (phase[PH_X3]) second <= second ? 1'b0 : is_two_word(opc_byte);
        end
    end

`ifdef ROM_RESPONDER_IO_EN
    logic sel;

    // A second-word frame carries data, not an instruction, so it must
    // never be mistaken for SRC/WRR/RDR.
    assign rdr_drive = phase[PH_X2] && sel && !second && (opc_byte == OPC_RDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            sel  <= 1'b0;
            io_o <= 4'h0;
        end else if (!halt && phase[PH_X2] && !second) begin
            if (rom_cmd && is_src(opc_byte)) sel <= (data_i == CHIP_ID);
            if (sel && (opc_byte == OPC_WRR)) io_o <= data_i;
        end
    end
`else
    logic io_unused;

    assign rdr_drive = 1'b0;
    assign io_o      = 4'h0;
    assign io_unused = ^io_i;
`endif

    // Bus drive: registered state only, never data_i.
    always_comb begin
        data_en = 1'b0;
        data_o  = 4'h0;
        if (frame_valid && hit && phase[PH_M1]) begin
            data_en = 1'b1;
            data_o  = rd_byte[7:4];
        end else if (frame_valid && hit && phase[PH_M2]) begin
            data_en = 1'b1;
            data_o  = rd_byte[3:0];
        end else if (rdr_drive) begin
            data_en = 1'b1;
`ifdef ROM_RESPONDER_IO_EN
            data_o  = io_i;
`endif
        end
    end

endmodule

// File: tb/tb_rom_responder.sv
module tb_rom_responder;

    localparam logic [3:0] CHIP = 4'h2;
`ifdef ROM_RESPONDER_IO_EN
    localparam bit IOE = 1'b1;
`else
    localparam bit IOE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       halt = 1'b0;
    logic       sync = 1'b0;
    logic       rom_cmd = 1'b0;
    logic [3:0] data_i = 4'h0;
    logic [3:0] data_o;
    logic       data_en;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = 8'h00;
    logic [7:0] prog_data = 8'h00;
    logic [3:0] io_i = 4'h0;
    logic [3:0] io_o;

    always #5 clock = ~clock;

    rom_responder #(.CHIP_ID(CHIP), .DEPTH(256)) dut (
        .clock     (clock),
        .reset     (reset),
        .halt      (halt),
        .sync      (sync),
        .rom_cmd   (rom_cmd),
        .data_i    (data_i),
        .data_o    (data_o),
        .data_en   (data_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .io_i      (io_i),
        .io_o      (io_o)
    );

    typedef struct {
        logic [3:0] a1, a2, a3, m1, m2, x2, io_in;
        logic       ca3, cx2;
        logic [4:0] em1, em2, ex2;
        logic [3:0] eio;
    } vec_t;

    int total = 0;
    int bad = 0;

    // Reference model state: frame-level view of the chip.
    logic [7:0] mdl_mem [256];
    logic       mdl_second = 1'b0;
    logic       mdl_sel = 1'b0;
    logic [3:0] mdl_io = 4'h0;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] a1, a2, a3, input logic ca3,
                                input logic [3:0] m1, m2, x2, input logic cx2,
                                input logic [3:0] io_in,
                                input logic [4:0] em1, em2, ex2, input logic [3:0] eio);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.a3 = a3; v.ca3 = ca3;
        v.m1 = m1; v.m2 = m2; v.x2 = x2; v.cx2 = cx2; v.io_in = io_in;
        v.em1 = em1; v.em2 = em2; v.ex2 = ex2; v.eio = eio;
        return v;
    endfunction

    function automatic logic [7:0] pick_op();
        logic [3:0] r;
        r = 4'($urandom);
        case ($urandom_range(0, 9))
            0: return 8'h21;
            1: return 8'h23;
            2: return 8'hE2;
            3: return 8'hEA;
            4: return {4'h4, r};
            5: return 8'h30;
            6: return 8'h31;
            7: return {4'h1, r};
            8: return {4'h7, r};
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic vec_t rnd_vec();
        logic [7:0] b;
        b = pick_op();
        return mk(4'($urandom), 4'($urandom),
                  $urandom_range(0, 1) ? CHIP : 4'($urandom), 1'($urandom),
                  b[7:4], b[3:0],
                  $urandom_range(0, 1) ? CHIP : 4'($urandom), 1'($urandom),
                  4'($urandom), 5'h0, 5'h0, 5'h0, 4'h0);
    endfunction

    task automatic check(input string nm, input int c, input logic [4:0] got, input logic [4:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s c%0d: got %h want %h", nm, c, got, want);
        end
    endtask

    // Whole-frame reference: which byte is on the bus, what the chip drives,
    // and how select / port / second-word state change.
    task automatic model_frame(input vec_t v, output logic [4:0] e1, output logic [4:0] e2,
                               output logic [4:0] ex, output logic [3:0] eio);
        logic       h;
        logic [7:0] b;
        logic [3:0] opr;
        h   = v.ca3 && (v.a3 == CHIP);
        b   = h ? mdl_mem[{v.a2, v.a1}] : {v.m1, v.m2};
        opr = b[7:4];
        e1  = h ? {1'b1, b[7:4]} : 5'h0;
        e2  = h ? {1'b1, b[3:0]} : 5'h0;
        ex  = 5'h0;
        if (IOE && !mdl_second) begin
            if (b == 8'hEA && mdl_sel) ex = {1'b1, v.io_in};
            if (b == 8'hE2 && mdl_sel) mdl_io = v.x2;
            if (opr == 4'h2 && b[0] && v.cx2) mdl_sel = (v.x2 == CHIP);
        end
        eio = mdl_io;
        if (mdl_second)
            mdl_second = 1'b0;
        else
            mdl_second = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
                         (((opr == 4'h2) || (opr == 4'h3)) && !b[0]);
    endtask

    task automatic cycle(input logic [3:0] di, input logic cmd, input logic syn,
                         input logic chk, input logic [4:0] want, input string nm, input int c);
        data_i  = di;
        rom_cmd = cmd;
        sync    = syn;
        @(negedge clock);
        if (chk) check(nm, c, {data_en, data_o}, want);
        @(posedge clock);
        #1;
    endtask

    task automatic drive_frame(input vec_t v, input logic [4:0] e1, input logic [4:0] e2,
                               input logic [4:0] ex, input logic [3:0] eio, input string nm,
                               input int halt_at, input int halt_len);
        for (int c = 0; c < 8; c++) begin
            logic [3:0] di;
            logic       cmd;
            logic [4:0] want;
            case (c)
                0: di = v.a1;
                1: di = v.a2;
                2: di = v.a3;
                3: di = v.m1;
                4: di = v.m2;
                6: di = v.x2;
                default: di = 4'h0;
            endcase
            cmd  = (c == 2) ? v.ca3 : (c == 6) ? v.cx2 : 1'b0;
            want = (c == 3) ? e1 : (c == 4) ? e2 : (c == 6) ? ex : 5'h0;
            io_i = v.io_in;
            if (c == halt_at) begin
                halt = 1'b1;
                for (int k = 0; k < halt_len; k++) begin
                    prog_we   = (k == 0);
                    prog_addr = 8'h77;
                    prog_data = 8'h3C;
                    cycle(~di, ~cmd, 1'b0, 1'b1, want, {nm, "_halt"}, c);
                end
                prog_we = 1'b0;
                halt    = 1'b0;
            end
            cycle(di, cmd, (c == 7), 1'b1, want, nm, c);
        end
        check({nm, "_io"}, 8, {1'b0, io_o}, {1'b0, eio});
    endtask

    task automatic model_and_drive(input vec_t v, input string nm, input int halt_at, input int halt_len);
        logic [4:0] e1, e2, ex;
        logic [3:0] eio;
        model_frame(v, e1, e2, ex, eio);
        drive_frame(v, e1, e2, ex, eio, nm, halt_at, halt_len);
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        mdl_mem[a] = d;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
    endtask

    initial begin
        logic [4:0] e1, e2, ex;
        logic [3:0] eio;
        vec_t v;

        tbl[0]  = mk(4'hA, 4'h5, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h1D, 5'h17, 5'h00, 4'h0);
        tbl[1]  = mk(4'hA, 4'h5, 4'h3, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h00, 5'h00, 5'h00, 4'h0);
        tbl[2]  = mk(4'h0, 4'h1, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h14, 5'h13, 5'h00, 4'h0);
        tbl[3]  = mk(4'hB, 4'h5, 4'h2, 1, 4'h0, 4'h0, 4'h2, 1, 4'h0, 5'h12, 5'h11, 5'h00, 4'h0);
        tbl[4]  = mk(4'h1, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h9, 0, 4'h0, 5'h1E, 5'h12, 5'h00, 4'h0);
        tbl[5]  = mk(4'h0, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h5, 1, 4'h0, 5'h12, 5'h11, 5'h00, 4'h0);
        tbl[6]  = mk(4'h1, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h9, 0, 4'h0, 5'h1E, 5'h12, 5'h00, 4'h0);
        tbl[7]  = mk(4'h0, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h2, 1, 4'h0, 5'h12, 5'h11, 5'h00, 4'h0);
        tbl[8]  = mk(4'h1, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h9, 0, 4'h0, 5'h1E, 5'h12, 5'h00, IOE ? 4'h9 : 4'h0);
        tbl[9]  = mk(4'h2, 4'h2, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'hC, 5'h1E, 5'h1A,
                     IOE ? 5'h1C : 5'h00, IOE ? 4'h9 : 4'h0);
        tbl[10] = mk(4'h0, 4'h0, 4'h5, 1, 4'h2, 4'h3, 4'h5, 1, 4'h0, 5'h00, 5'h00, 5'h00, IOE ? 4'h9 : 4'h0);
        tbl[11] = mk(4'h0, 4'h0, 4'h7, 1, 4'hE, 4'hA, 4'h0, 0, 4'h3, 5'h00, 5'h00, 5'h00, IOE ? 4'h9 : 4'h0);
        tbl[12] = mk(4'h0, 4'h0, 4'h7, 0, 4'h2, 4'h1, 4'h2, 1, 4'h0, 5'h00, 5'h00, 5'h00, IOE ? 4'h9 : 4'h0);
        tbl[13] = mk(4'h0, 4'h0, 4'h7, 0, 4'hE, 4'hA, 4'h0, 0, 4'h6, 5'h00, 5'h00,
                     IOE ? 5'h16 : 5'h00, IOE ? 4'h9 : 4'h0);

        repeat (2) @(posedge clock);
        #1;
        for (int a = 0; a < 256; a++) prog_write(8'(a), pick_op());
        prog_write(8'h5A, 8'hD7);
        prog_write(8'h5B, 8'h21);
        prog_write(8'h10, 8'h43);
        prog_write(8'h20, 8'h21);
        prog_write(8'h21, 8'hE2);
        prog_write(8'h22, 8'hEA);
        prog_write(8'h77, 8'h00);

        // Reset state
        @(negedge clock);
        check("reset_drive", 0, {data_en, data_o}, 5'h00);
        check("reset_io", 0, {1'b0, io_o}, 5'h00);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // IDLE holds without sync even with a matching address pattern
        cycle(4'hA, 1'b0, 1'b0, 1'b1, 5'h00, "idle", 0);
        cycle(4'h2, 1'b1, 1'b0, 1'b1, 5'h00, "idle", 1);
        cycle(4'h0, 1'b0, 1'b0, 1'b1, 5'h00, "idle", 2);
        cycle(4'h0, 1'b0, 1'b1, 1'b1, 5'h00, "idle_sync", 3);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            model_frame(tbl[i], e1, e2, ex, eio);
            drive_frame(tbl[i], tbl[i].em1, tbl[i].em2, tbl[i].ex2, tbl[i].eio,
                        $sformatf("tbl%0d", i), -1, 0);
        end

        // Resync in M1: partial frame abandoned, next cycle is A1
        cycle(4'hA, 1'b0, 1'b0, 1'b1, 5'h00, "resync", 0);
        cycle(4'h5, 1'b0, 1'b0, 1'b1, 5'h00, "resync", 1);
        cycle(4'h2, 1'b1, 1'b0, 1'b1, 5'h00, "resync", 2);
        cycle(4'h0, 1'b0, 1'b1, 1'b0, 5'h00, "resync", 3);
        v = mk(4'hA, 4'h5, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h0, 5'h0, 5'h0, 4'h0);
        model_and_drive(v, "after_resync", -1, 0);

        // Halt mid-frame; program store keeps accepting writes while halted
        mdl_mem[8'h77] = 8'h3C;
        model_and_drive(v, "halt_m1", 3, 3);
        v = mk(4'h7, 4'h7, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h0, 5'h0, 5'h0, 4'h0);
        model_and_drive(v, "halt_a2", 1, 3);
        v = mk(4'h0, 4'h0, 4'h9, 1, 4'h2, 4'h1, 4'h5, 1, 4'h0, 5'h0, 5'h0, 5'h0, 4'h0);
        model_and_drive(v, "fin_data", -1, 0);

        // Reset in M2: drive continues this cycle, stops after the edge
        cycle(4'hA, 1'b0, 1'b0, 1'b1, 5'h00, "rst", 0);
        cycle(4'h5, 1'b0, 1'b0, 1'b1, 5'h00, "rst", 1);
        cycle(4'h2, 1'b1, 1'b0, 1'b1, 5'h00, "rst", 2);
        cycle(4'h0, 1'b0, 1'b0, 1'b1, {1'b1, mdl_mem[8'h5A][7:4]}, "rst", 3);
        reset = 1'b1;
        cycle(4'h0, 1'b0, 1'b0, 1'b1, {1'b1, mdl_mem[8'h5A][3:0]}, "rst", 4);
        reset = 1'b0;
        mdl_sel    = 1'b0;
        mdl_second = 1'b0;
        mdl_io     = 4'h0;
        check("rst_io", 5, {1'b0, io_o}, 5'h00);
        for (int c = 0; c < 8; c++) begin
            cycle((c == 0) ? 4'hA : (c == 1) ? 4'h5 : (c == 2) ? 4'h2 : 4'h0,
                  (c == 2), 1'b0, 1'b1, 5'h00, "post_rst_idle", c);
        end
        cycle(4'h0, 1'b0, 1'b1, 1'b1, 5'h00, "post_rst_sync", 0);
        v = mk(4'hA, 4'h5, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 5'h0, 5'h0, 5'h0, 4'h0);
        model_and_drive(v, "post_rst_fetch", -1, 0);

        // Randomized frames against the model
        for (int n = 0; n < 150; n++) begin
            int ha;
            ha = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            model_and_drive(rnd_vec(), $sformatf("rnd%0d", n), ha, int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
